// File: rtl/lsu_ctrl.sv
// Load/store controller: one memory access at a time, lane steering and load extension.
// Latency: response 3 cycles after accept with zero-wait memory, 1 cycle for misaligned.
// Backpressure: req_ready only in IDLE; holds the memory request and the response until taken.
// Optional LSU_MISALIGN_CHECK_EN: reject misaligned accesses with rsp_err instead of forcing alignment.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [1:0]  off;
    logic        misalign;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;
    logic        accept;

    assign accept        = req_valid && req_ready;
    assign req_ready     = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign rsp_valid     = (state_q == RESP);

    // Byte offset used for lane steering; without the check, sub-size bits are dropped.
    always_comb begin
        off      = req_addr[1:0];
        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
`else
        case (req_size)
            2'b00:   off = req_addr[1:0];
            2'b01:   off = {req_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
`endif
    end

    always_comb begin
        lane_wdata = req_wdata;
        lane_wstrb = 4'b1111;
        case (req_size)
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wstrb = 4'b0011 << off;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)     state_d = misalign ? RESP : REQ;
            REQ:  if (mem_req_ready) state_d = WAIT;
            WAIT: if (mem_rsp_valid) state_d = RESP;
            RESP: if (rsp_ready)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            uns_q     <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wen   <= req_wen;
                mem_wdata <= lane_wdata;
                mem_wstrb <= req_wen ? lane_wstrb : 4'b0000;
                size_q    <= req_size;
                off_q     <= off;
                uns_q     <= req_unsigned;
                rsp_rdata <= '0;
            end
            if ((state_q == WAIT) && mem_rsp_valid)
                rsp_rdata <= mem_wen ? 32'h0 : ld_data;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)         err_q <= 1'b0;
        else if (accept) err_q <= misalign;
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a spec-level model of lanes, extension and latency.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_chk = 0;
    int n_err = 0;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: what the access should look like on the memory side and in the response.
    task automatic model(input logic [31:0] addr, input logic [31:0] wd_in, input logic [1:0] size,
                         input logic uns, input logic wen, input logic [31:0] rdata,
                         output logic mis, output logic [3:0] strb, output logic [31:0] wd,
                         output logic [31:0] rd);
        int off;
        logic [31:0] s;
        off = int'(addr[1:0]);
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (size == 2'd1 && (off % 2) != 0) mis = 1'b1;
        if (size >= 2'd2 && off != 0)       mis = 1'b1;
`else
        if (size == 2'd1) off = off - (off % 2);
        if (size >= 2'd2) off = 0;
`endif
        case (size)
            2'd0: begin strb = 4'(1 << off); wd = (wd_in & 32'hFF) * 32'h01010101; end
            2'd1: begin strb = 4'(3 << off); wd = (wd_in & 32'hFFFF) * 32'h00010001; end
            default: begin strb = 4'hF; wd = wd_in; end
        endcase
        if (!wen) strb = 4'h0;
        s = rdata >> (8 * off);
        case (size)
            2'd0: begin
                rd = s & 32'hFF;
                if (!uns && rd >= 32'h80) rd = rd + 32'hFFFFFF00;
            end
            2'd1: begin
                rd = s & 32'hFFFF;
                if (!uns && rd >= 32'h8000) rd = rd + 32'hFFFF0000;
            end
            default: rd = s;
        endcase
        if (wen) rd = 32'h0;
    endtask

    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                          input int stall, input int hold);
        logic        mis;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_rd;
        int cyc, seen, st, exp_lat;
        bit hs;
        model(addr, wdata, size, uns, wen, rdata, mis, e_strb, e_wd, e_rd);
        exp_lat = mis ? 1 : 3 + stall;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        check("acc_rdy", 32'(req_ready), 32'd1);
        step;
        // Scramble request fields: they must only be sampled at acceptance.
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
        cyc = 1; seen = 0; st = 0; hs = 0;
        while (!rsp_valid && cyc < 40) begin
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            req_valid = 1'($urandom);
            if (hs) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = rdata;
                hs = 0;
            end else if (mem_req_valid) begin
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_wen", 32'(mem_wen), 32'(wen));
                check("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
                if (wen) check("mem_wdata", mem_wdata, e_wd);
                seen++;
                if (st < stall) st++;
                else begin mem_req_ready = 1'b1; hs = 1; end
                mem_rsp_valid = 1'($urandom);
                mem_rdata = $urandom;
            end
            step;
            cyc++;
        end
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; req_valid = 1'b0;
        check("rsp_vld", 32'(rsp_valid), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("mem_reqs", 32'(seen), mis ? 32'd0 : 32'(stall + 1));
        check("rsp_err", 32'(rsp_err), 32'(mis));
        if (!mis) check("rsp_rdata", rsp_rdata, e_rd);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rdata = $urandom;
            req_valid = 1'b1;
            step;
            check("hold_vld", 32'(rsp_valid), 32'd1);
            check("hold_rdy", 32'(req_ready), 32'd0);
            check("hold_mreq", 32'(mem_req_valid), 32'd0);
            if (!mis) check("hold_rdata", rsp_rdata, e_rd);
            check("hold_err", 32'(rsp_err), 32'(mis));
        end
        mem_rsp_valid = 1'b0; req_valid = 1'b0;
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        check("idle_rdy", 32'(req_ready), 32'd1);
        check("idle_vld", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        step;
        step;
        check("rst_req_rdy", 32'(req_ready), 32'd1);
        check("rst_rsp_vld", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mreq", 32'(mem_req_valid), 32'd0);
        check("rst_mwen", 32'(mem_wen), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        step;

        do_txn(1'b1, 32'h8000_0003, 32'h1234_56AB, 2'd0, 1'b0, 32'h0, 0, 0);
        do_txn(1'b0, 32'h0000_0102, 32'h0, 2'd1, 1'b0, 32'h8765_4321, 0, 0);
        do_txn(1'b0, 32'h0000_0102, 32'h0, 2'd1, 1'b1, 32'h8765_4321, 0, 0);
        do_txn(1'b0, 32'h0000_0200, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 0);
        do_txn(1'b0, 32'h0000_0200, 32'h0, 2'd2, 1'b0, 32'h1357_9BDF, 4, 0);
        do_txn(1'b0, 32'h0000_0202, 32'h0, 2'd2, 1'b0, 32'hA5A5_5A5A, 0, 0);
        do_txn(1'b0, 32'h0000_0301, 32'h0, 2'd0, 1'b0, 32'h0000_8000, 0, 5);
        do_txn(1'b1, 32'h0000_0042, 32'hDEAD_BEEF, 2'd1, 1'b0, 32'h0, 1, 0);

        // Reset while waiting for the memory response.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h40; req_size = 2'd2;
        step;
        req_valid = 1'b0; mem_req_ready = 1'b1;
        step;
        mem_req_ready = 1'b0;
        check("wait_mreq", 32'(mem_req_valid), 32'd0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("mid_rst_rdy", 32'(req_ready), 32'd1);
        check("mid_rst_vld", 32'(rsp_valid), 32'd0);
        check("mid_rst_mreq", 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            step;
            check("stale_vld", 32'(rsp_valid), 32'd0);
            check("stale_rdy", 32'(req_ready), 32'd1);
        end
        mem_rsp_valid = 1'b0;
        do_txn(1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 2'd2, 1'b0, 32'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
